// File: rtl/bht_port_scheduler.sv
// bht_port_scheduler: shares the single BHT port between fetch lookups, buffered execute updates and table clears.
module bht_port_scheduler #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             fetch_req,
  input  logic [LOWER-1:0] fetch_addr,
  output logic             fetch_stall,
  input  logic             upd_valid,
  input  logic [LOWER-1:0] upd_addr,
  input  logic             upd_taken,
  output logic             upd_ready,
  input  logic             init_req,
  output logic             busy,
  output logic             bht_rd_en,
  output logic [LOWER-1:0] bht_rd_addr,
  output logic             bht_wr_en,
  output logic [LOWER-1:0] bht_wr_addr,
  output logic             bht_wr_taken,
  output logic             bht_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t           state, state_nx;
  logic [LOWER-1:0] clr_idx;
  logic [LOWER-1:0] mem_addr [DEPTH];
  logic             mem_taken [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             run, init, full, empty, push, pop;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // Outputs are gated by arst_n so they fall to reset values without a clock edge.
  assign run   = arst_n && state == RUN;
  assign init  = arst_n && state == INIT;
  assign push  = run && upd_valid && !full && !init_req;
  assign pop   = run && !empty && (!fetch_req || full);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state <= INIT;
    else state <= state_nx;
  always_comb
    state_nx = init_req ? INIT : (state == INIT && &clr_idx) ? RUN : state;
  always_comb begin
    fetch_stall  = !run || (fetch_req && full);
    upd_ready    = run && !full;
    busy         = !run;
    bht_rd_en    = run && fetch_req && !full;
    bht_rd_addr  = bht_rd_en ? fetch_addr : '0;
    bht_wr_en    = init || pop;
    bht_clr      = init;
    bht_wr_addr  = init ? clr_idx : pop ? mem_addr[rd_ptr] : '0;
    bht_wr_taken = pop && mem_taken[rd_ptr];
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) clr_idx <= '0;
    else clr_idx <= (init_req || state == RUN) ? '0 : clr_idx + 1'b1;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (init_req || state == INIT) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      count  <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_addr[wr_ptr]  <= upd_addr;
      mem_taken[wr_ptr] <= upd_taken;
    end
endmodule
